// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, then clocks one command byte out on device clock edges.
// Drives the shared open-collector pins only through the oe outputs, never high.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2841,
  parameter int TIMEOUT_CYCLES = 426135
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       timeout,
  output logic [2:0] state_dbg
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_BITS      = 3'd2,
    S_ACK       = 3'd3,
    S_WAIT_IDLE = 3'd4,
    S_END       = 3'd5
  } state_t;

  state_t state, state_nx;

  logic             clk_s1, clk_s2, clk_prev;
  logic             data_s1, data_s2;
  logic [7:0]       shreg;
  logic             par;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             nack_flag;
  logic             clk_oe_d, data_oe_d, done_d, nack_d, timeout_d;
  logic             fe, inh_last, to_hit, counting;

  // Handshake: tx_data is taken on any cycle where tx_valid && tx_ready; tx_ready is high only in IDLE.
  assign tx_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  assign fe       = clk_prev & ~clk_s2;
  assign inh_last = (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
  assign to_hit   = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign counting = (state == S_BITS) || (state == S_ACK) || (state == S_WAIT_IDLE);

  // Idle bus level is high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (tx_valid) state_nx = S_INHIBIT;
      S_INHIBIT:   if (inh_last) state_nx = S_BITS;
      S_BITS:      if (to_hit) state_nx = S_END;
                   else if (fe && bit_cnt == 4'd9) state_nx = S_ACK;
      S_ACK:       if (to_hit) state_nx = S_END;
                   else if (fe) state_nx = S_WAIT_IDLE;
      S_WAIT_IDLE: if (to_hit || (clk_s2 && data_s2)) state_nx = S_END;
      default:     state_nx = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; timeout takes priority over a same-cycle edge.
  always_comb begin
    clk_oe_d  = ps2_clk_oe;
    data_oe_d = ps2_data_oe;
    done_d    = 1'b0;
    nack_d    = 1'b0;
    timeout_d = 1'b0;
    case (state)
      S_IDLE: if (tx_valid) begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b0;
      end
      S_INHIBIT: if (inh_last) begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b1;
      end
      S_BITS, S_ACK, S_WAIT_IDLE: begin
        if (to_hit) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          timeout_d = 1'b1;
        end else if (state == S_BITS && fe) begin
          if (bit_cnt < 4'd8)       data_oe_d = ~shreg[0];
          else if (bit_cnt == 4'd8) data_oe_d = ~par;
          else                      data_oe_d = 1'b0;
        end else if (state == S_WAIT_IDLE && clk_s2 && data_s2) begin
          done_d = 1'b1;
          nack_d = nack_flag;
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      nack        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
      done        <= done_d;
      nack        <= nack_d;
      timeout     <= timeout_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg     <= '0;
      par       <= 1'b0;
      bit_cnt   <= '0;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      nack_flag <= 1'b0;
    end else begin
      if (state == S_IDLE && tx_valid) begin
        shreg   <= tx_data;
        par     <= ~^tx_data;
        bit_cnt <= '0;
        inh_cnt <= '0;
      end
      if (state == S_INHIBIT) begin
        inh_cnt <= inh_cnt + 1'b1;
        if (inh_last) to_cnt <= '0;
      end
      if (counting) to_cnt <= fe ? '0 : to_cnt + 1'b1;
      if ((state == S_BITS || state == S_ACK) && fe && !to_hit) begin
        bit_cnt <= (bit_cnt == 4'd11) ? bit_cnt : bit_cnt + 4'd1;
        if (state == S_BITS && bit_cnt < 4'd8) shreg <= {1'b0, shreg[7:1]};
        if (state == S_ACK) nack_flag <= data_s2;
      end
    end
  end

endmodule
